// File: rtl/wit_arbiter_if.sv
// Request, response and table-port bundle for wit_arbiter.
// slave: arbiter view; master: requester/table view.
interface wit_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              set_valid;
    logic              set_ready;
    logic [ADDR_W-1:0] set_qpn;
    logic              clr_valid;
    logic              clr_ready;
    logic [ADDR_W-1:0] clr_qpn;
    logic              lkp_valid;
    logic              lkp_ready;
    logic [ADDR_W-1:0] lkp_qpn;
    logic              rsp_valid;
    logic              rsp_data;
    logic              wit_wr_en;
    logic [ADDR_W-1:0] wit_wr_addr;
    logic              wit_wr_data;
    logic [ADDR_W-1:0] wit_rd_addr;
    logic              wit_rd_data;

    modport slave (
        input  set_valid, set_qpn, clr_valid, clr_qpn, lkp_valid, lkp_qpn, wit_rd_data,
        output set_ready, clr_ready, lkp_ready, rsp_valid, rsp_data,
               wit_wr_en, wit_wr_addr, wit_wr_data, wit_rd_addr
    );

    modport master (
        output set_valid, set_qpn, clr_valid, clr_qpn, lkp_valid, lkp_qpn, wit_rd_data,
        input  set_ready, clr_ready, lkp_ready, rsp_valid, rsp_data,
               wit_wr_en, wit_wr_addr, wit_wr_data, wit_rd_addr
    );
endinterface

// File: rtl/wit_arbiter.sv
// WIT indicator-table arbiter: clears the table after reset, then arbitrates
// set/clear writes round-robin and serves single-cycle-latency lookups.
// Optional macro WIT_COLLISION_FWD_EN forwards a same-cycle write to a
// lookup of the same QPN.
module wit_arbiter #(
    parameter int QP_NUM = 8192,
    parameter int ADDR_W = 14
) (
    input  logic          clk,
    input  logic          rst,
    wit_arbiter_if.slave  bus,
    output logic          init_done
);

    localparam logic [0:0]        ST_INIT   = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(QP_NUM - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              rr_q, rr_d;          // 1: clear port has priority next
    logic              rsp_valid_q, rsp_valid_d;
`ifdef WIT_COLLISION_FWD_EN
    logic              fwd_hit_q, fwd_hit_d;
    logic              fwd_val_q, fwd_val_d;
`endif

    logic              run;
    logic              set_acc;
    logic              clr_acc;
    logic              lkp_acc;
    logic              wr_any;
    logic [ADDR_W-1:0] wr_addr_run;

    // Handshake readies and round-robin grant between the two write ports
    always_comb begin
        run           = (state_q == ST_RUN);
        bus.set_ready = run && (!bus.clr_valid || !rr_q);
        bus.clr_ready = run && (!bus.set_valid || rr_q);
        bus.lkp_ready = run;
        set_acc       = bus.set_valid && bus.set_ready;
        clr_acc       = bus.clr_valid && bus.clr_ready;
        lkp_acc       = bus.lkp_valid && bus.lkp_ready;
        wr_any        = set_acc || clr_acc;
        wr_addr_run   = set_acc ? bus.set_qpn : bus.clr_qpn;
    end

    // Table write/read ports: clear sweep in INIT, granted request in RUN
    always_comb begin
        bus.wit_wr_en   = 1'b0;
        bus.wit_wr_addr = '0;
        bus.wit_wr_data = 1'b0;
        if (rst) begin
            bus.wit_wr_en = 1'b0;
        end else if (!run) begin
            bus.wit_wr_en   = 1'b1;
            bus.wit_wr_addr = init_addr_q;
            bus.wit_wr_data = 1'b0;
        end else begin
            bus.wit_wr_en   = wr_any;
            bus.wit_wr_addr = wr_addr_run;
            bus.wit_wr_data = set_acc;
        end
        bus.wit_rd_addr = bus.lkp_qpn;
    end

    // Next-state: init sweep counter, FSM, pointer and response strobe
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rr_d        = rr_q;
        rsp_valid_d = lkp_acc;
        case (state_q)
            ST_INIT: begin
                if (init_addr_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_addr_d = '0;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            default: begin
                if (set_acc) begin
                    rr_d = 1'b1;
                end else if (clr_acc) begin
                    rr_d = 1'b0;
                end
            end
        endcase
    end

`ifdef WIT_COLLISION_FWD_EN
    // Remember a same-cycle write to the looked-up QPN so it overrides stale table data
    always_comb begin
        fwd_hit_d = lkp_acc && wr_any && (wr_addr_run == bus.lkp_qpn);
        fwd_val_d = set_acc;
    end

    // Forwarding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_q <= 1'b0;
            fwd_val_q <= 1'b0;
        end else begin
            fwd_hit_q <= fwd_hit_d;
            fwd_val_q <= fwd_val_d;
        end
    end
`endif

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            rr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Response outputs; data is held at 0 outside the response strobe
    always_comb begin
        init_done     = run;
        bus.rsp_valid = rsp_valid_q;
`ifdef WIT_COLLISION_FWD_EN
        bus.rsp_data  = rsp_valid_q && (fwd_hit_q ? fwd_val_q : bus.wit_rd_data);
`else
        bus.rsp_data  = rsp_valid_q && bus.wit_rd_data;
`endif
    end

endmodule

// File: tb/tb_wit_arbiter.sv
// Self-checking bench for wit_arbiter: init sweep, reset restart, directed
// vector table, back-to-back lookups and randomized traffic against a model.
module tb_wit_arbiter;

    localparam int QP_NUM = 8192;
    localparam int ADDR_W = 14;

    logic clk;
    logic rst;
    logic init_done;

    int n_checks = 0;
    int n_errors = 0;

    wit_arbiter_if #(.ADDR_W(ADDR_W)) bus_if ();

    wit_arbiter #(.QP_NUM(QP_NUM), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table memory, stored inverted so that it powers up reading all-ones
    // and only the DUT's clear sweep can make it read zero.
    bit mem_n [2**ADDR_W];
    always @(posedge clk) begin
        if (bus_if.wit_wr_en) mem_n[bus_if.wit_wr_addr] <= ~bus_if.wit_wr_data;
        bus_if.wit_rd_data <= ~mem_n[bus_if.wit_rd_addr];
    end

    // Reference model state
    bit model_tbl [QP_NUM];
    bit last_set;              // last granted write port was set
    bit pend_v, pend_d, pend_dc;

    typedef struct {
        bit sv; int sq; bit cv; int cq; bit lv; int lq;
        bit e_sr; bit e_cr; bit e_en; int e_addr; bit e_dat; bit e_rv; bit e_rd;
    } vec_t;

    vec_t tbl [27];

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chka(input string name, input logic [ADDR_W-1:0] got, input int exp);
        n_checks++;
        if (got !== ADDR_W'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit sv, input int sq, input bit cv, input int cq,
                         input bit lv, input int lq);
        bus_if.set_valid = sv;
        bus_if.set_qpn   = ADDR_W'(sq);
        bus_if.clr_valid = cv;
        bus_if.clr_qpn   = ADDR_W'(cq);
        bus_if.lkp_valid = lv;
        bus_if.lkp_qpn   = ADDR_W'(lq);
    endtask

    task automatic model_reset();
        for (int i = 0; i < QP_NUM; i++) model_tbl[i] = 1'b0;
        last_set = 1'b0;
        pend_v   = 1'b0;
        pend_d   = 1'b0;
        pend_dc  = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_set_ready", bus_if.set_ready, 1'b0);
        chk1("rst_clr_ready", bus_if.clr_ready, 1'b0);
        chk1("rst_lkp_ready", bus_if.lkp_ready, 1'b0);
        chk1("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        chk1("rst_rsp_data", bus_if.rsp_data, 1'b0);
        chk1("rst_wr_en", bus_if.wit_wr_en, 1'b0);
        chk1("rst_init_done", init_done, 1'b0);
    endtask

    // n cycles of the clear sweep with random (ignored) requests applied
    task automatic check_init(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            @(negedge clk);
            chk1("init_wr_en", bus_if.wit_wr_en, 1'b1);
            chk1("init_wr_data", bus_if.wit_wr_data, 1'b0);
            chka("init_wr_addr", bus_if.wit_wr_addr, i);
            chk1("init_set_ready", bus_if.set_ready, 1'b0);
            chk1("init_clr_ready", bus_if.clr_ready, 1'b0);
            chk1("init_lkp_ready", bus_if.lkp_ready, 1'b0);
            chk1("init_rsp_valid", bus_if.rsp_valid, 1'b0);
            chk1("init_done_low", init_done, 1'b0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_run_entry();
        @(negedge clk);
        chk1("run_init_done", init_done, 1'b1);
        chk1("run_set_ready", bus_if.set_ready, 1'b1);
        chk1("run_clr_ready", bus_if.clr_ready, 1'b1);
        chk1("run_lkp_ready", bus_if.lkp_ready, 1'b1);
        chk1("run_wr_en_idle", bus_if.wit_wr_en, 1'b0);
        chk1("run_rsp_valid", bus_if.rsp_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    // One RUN cycle checked against the model
    task automatic model_cycle(input bit sv, input int sq, input bit cv, input int cq,
                               input bit lv, input int lq);
        bit set_win, clr_win, wr, wdat;
        int waddr;
        drive(sv, sq, cv, cq, lv, lq);
        // with both requesting, the grant goes to the port not granted last
        if (sv && cv) begin
            set_win = !last_set;
            clr_win = last_set;
        end else begin
            set_win = sv;
            clr_win = cv;
        end
        wr    = set_win || clr_win;
        waddr = set_win ? sq : cq;
        wdat  = set_win;
        @(negedge clk);
        if (sv) chk1("set_ready", bus_if.set_ready, set_win);
        if (cv) chk1("clr_ready", bus_if.clr_ready, clr_win);
        chk1("lkp_ready", bus_if.lkp_ready, 1'b1);
        chk1("wr_en", bus_if.wit_wr_en, wr);
        if (wr) begin
            chka("wr_addr", bus_if.wit_wr_addr, waddr);
            chk1("wr_data", bus_if.wit_wr_data, wdat);
        end
        chk1("rsp_valid", bus_if.rsp_valid, pend_v);
        if (pend_v && !pend_dc) chk1("rsp_data", bus_if.rsp_data, pend_d);
        pend_v  = lv;
        pend_dc = 1'b0;
        pend_d  = model_tbl[lq];
        if (lv && wr && waddr == lq) begin
`ifdef WIT_COLLISION_FWD_EN
            pend_d = wdat;
`else
            pend_dc = 1'b1;
`endif
        end
        if (wr) begin
            model_tbl[waddr] = wdat;
            last_set         = set_win;
        end
        @(posedge clk); #1;
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            model_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
        end
        model_cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //            sv sq  cv cq  lv lq    sr cr en addr d  rv rd
        tbl[0]  = '{1, 5,   0, 0,  0, 0,    1, 0, 1, 5,  1, 0, 0};
        tbl[1]  = '{0, 0,   0, 0,  1, 5,    0, 0, 0, 0,  0, 0, 0};
        tbl[2]  = '{0, 0,   0, 0,  0, 0,    0, 0, 0, 0,  0, 1, 1};
        tbl[3]  = '{0, 0,   1, 5,  0, 0,    0, 1, 1, 5,  0, 0, 0};
        tbl[4]  = '{0, 0,   0, 0,  1, 5,    0, 0, 0, 0,  0, 0, 0};
        tbl[5]  = '{0, 0,   0, 0,  0, 0,    0, 0, 0, 0,  0, 1, 0};
        tbl[6]  = '{1, 10,  1, 11, 0, 0,    1, 0, 1, 10, 1, 0, 0};
        tbl[7]  = '{1, 10,  1, 11, 0, 0,    0, 1, 1, 11, 0, 0, 0};
        tbl[8]  = '{1, 10,  1, 11, 0, 0,    1, 0, 1, 10, 1, 0, 0};
        tbl[9]  = '{1, 10,  1, 11, 0, 0,    0, 1, 1, 11, 0, 0, 0};
        tbl[10] = '{0, 0,   0, 0,  1, 10,   0, 0, 0, 0,  0, 0, 0};
        tbl[11] = '{0, 0,   0, 0,  1, 11,   0, 0, 0, 0,  0, 1, 1};
        tbl[12] = '{0, 0,   0, 0,  0, 0,    0, 0, 0, 0,  0, 1, 0};
        tbl[13] = '{1, 20,  1, 20, 0, 0,    1, 0, 1, 20, 1, 0, 0};
        tbl[14] = '{1, 20,  1, 20, 0, 0,    0, 1, 1, 20, 0, 0, 0};
        tbl[15] = '{0, 0,   0, 0,  1, 20,   0, 0, 0, 0,  0, 0, 0};
        tbl[16] = '{0, 0,   0, 0,  0, 0,    0, 0, 0, 0,  0, 1, 0};
        tbl[17] = '{0, 0,   1, 21, 0, 0,    0, 1, 1, 21, 0, 0, 0};
        tbl[18] = '{1, 21,  0, 0,  0, 0,    1, 0, 1, 21, 1, 0, 0};
        tbl[19] = '{1, 23,  0, 0,  0, 0,    1, 0, 1, 23, 1, 0, 0};
        tbl[20] = '{1, 22,  1, 22, 0, 0,    0, 1, 1, 22, 0, 0, 0};
        tbl[21] = '{1, 22,  1, 22, 0, 0,    1, 0, 1, 22, 1, 0, 0};
        tbl[22] = '{0, 0,   0, 0,  1, 22,   0, 0, 0, 0,  0, 0, 0};
        tbl[23] = '{0, 0,   0, 0,  1, 21,   0, 0, 0, 0,  0, 1, 1};
        tbl[24] = '{0, 0,   0, 0,  1, 100,  0, 0, 0, 0,  0, 1, 1};
        tbl[25] = '{0, 0,   0, 0,  1, 8191, 0, 0, 0, 0,  0, 1, 0};
        tbl[26] = '{0, 0,   0, 0,  0, 0,    0, 0, 0, 0,  0, 1, 0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // abort the sweep at address 3000, then the full sweep must repeat
        check_init(3000);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        check_init(QP_NUM);
        chk_run_entry();

        // directed vectors
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].sv, tbl[i].sq, tbl[i].cv, tbl[i].cq, tbl[i].lv, tbl[i].lq);
            @(negedge clk);
            if (tbl[i].sv) chk1("vec_set_ready", bus_if.set_ready, tbl[i].e_sr);
            if (tbl[i].cv) chk1("vec_clr_ready", bus_if.clr_ready, tbl[i].e_cr);
            chk1("vec_lkp_ready", bus_if.lkp_ready, 1'b1);
            chk1("vec_wr_en", bus_if.wit_wr_en, tbl[i].e_en);
            if (tbl[i].e_en) begin
                chka("vec_wr_addr", bus_if.wit_wr_addr, tbl[i].e_addr);
                chk1("vec_wr_data", bus_if.wit_wr_data, tbl[i].e_dat);
                model_tbl[tbl[i].e_addr] = tbl[i].e_dat;
                last_set                 = tbl[i].e_dat;
            end
            chk1("vec_rsp_valid", bus_if.rsp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) chk1("vec_rsp_data", bus_if.rsp_data, tbl[i].e_rd);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0);

        // pattern on qpn 0..15, then 16 back-to-back lookups
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 0 || i == 15) model_cycle(1, i, 0, 0, 0, 0);
            else                       model_cycle(0, 0, 1, i, 0, 0);
        end
        for (int i = 0; i < 16; i++) model_cycle(0, 0, 0, 0, 1, i);
        model_cycle(0, 0, 0, 0, 0, 0);

`ifdef WIT_COLLISION_FWD_EN
        model_cycle(0, 0, 1, 7, 0, 0);
        model_cycle(1, 7, 0, 0, 1, 7);
        model_cycle(0, 0, 0, 0, 0, 0);
`endif

        random_traffic(1500);

        // reset with a response in flight: it must never appear
        drive(0, 0, 0, 0, 1, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_init(QP_NUM);
        chk_run_entry();
        random_traffic(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wit_arbiter.md
WIT_ARBITER -- requirements
Module: wit_arbiter

Interface
REQ-001 SHALL have parameter QP_NUM, default 8192, number of table entries initialized and addressable.
REQ-002 SHALL have parameter ADDR_W, default 14, width of QPN and table address.
REQ-003 SHALL have clk  input  1  sole clock.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have set_valid / set_ready  input / output  1 / 1  set-indicator request handshake.
REQ-006 SHALL have set_qpn  input  ADDR_W  QPN whose indicator becomes 1.
REQ-007 SHALL have clr_valid / clr_ready  input / output  1 / 1  clear-indicator request handshake.
REQ-008 SHALL have clr_qpn  input  ADDR_W  QPN whose indicator becomes 0.
REQ-009 SHALL have lkp_valid / lkp_ready  input / output  1 / 1  lookup request handshake.
REQ-010 SHALL have lkp_qpn  input  ADDR_W  QPN to look up.
REQ-011 SHALL have rsp_valid / rsp_data  output / output  1 / 1  lookup response strobe and indicator value.
REQ-012 SHALL have wit_wr_en, wit_wr_addr, wit_wr_data  output  1, ADDR_W, 1  table write port.
REQ-013 SHALL have wit_rd_addr / wit_rd_data  output / input  ADDR_W / 1  table read port; data valid 1 cycle after address.
REQ-014 SHALL have init_done  output  1  high once table clear completes.

Function
REQ-015 SHALL implement a two-state FSM: INIT (entered on reset) and RUN.
REQ-016 In INIT, SHALL write 0 to addresses 0..QP_NUM-1, one per cycle, ascending; after address QP_NUM-1 is written, next state SHALL be RUN.
REQ-017 In INIT, set_ready, clr_ready, lkp_ready and rsp_valid SHALL be 0.
REQ-018 init_done SHALL be 1 exactly when in RUN.
REQ-019 In RUN, at most one table write SHALL occur per cycle; a request is accepted when valid&&ready.
REQ-020 When only one write requester is valid, its ready SHALL be 1 combinationally.
REQ-021 When both are valid, SHALL grant round-robin, alternating from the last granted port; the losing port's ready SHALL be 0.
REQ-022 Round-robin pointer SHALL reset to favor set first, and update only on an accepted grant.
REQ-023 Accepted write SHALL drive wit_wr_en=1, wit_wr_addr=qpn, wit_wr_data=1 (set) or 0 (clear) in the same cycle, unregistered.
REQ-024 Same QPN on set and clr simultaneously SHALL be serialized by REQ-021; final value SHALL be that of the later-granted port.
REQ-025 In RUN, lkp_ready SHALL be 1 every cycle; wit_rd_addr SHALL equal lkp_qpn combinationally.
REQ-026 An accepted lookup in cycle t SHALL produce rsp_valid=1 in cycle t+1 only, and rsp_data for that QPN.
REQ-027 A write at cycle t SHALL be visible to a lookup accepted at cycle t+1 or later.
REQ-028 QPNs >= QP_NUM SHALL be passed through unchecked; behaviour on them is undefined.

Reset
REQ-029 On rst: FSM=INIT, init address counter=0, round-robin pointer=set, rsp_valid=0, rsp_data=0, init_done=0, all readies=0, wit_wr_en=0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abort all activity and restart the full clear sequence; in-flight responses SHALL be discarded.

Configuration
REQ-031 Macro WIT_COLLISION_FWD_EN SHALL be defined: a lookup and a write to the same QPN in the same cycle SHALL return the written value in rsp_data at t+1.
REQ-032 Macro WIT_COLLISION_FWD_EN SHALL be undefined: rsp_data SHALL be wit_rd_data unmodified; same-cycle collision value is undefined, and the bench SHALL not check it.

Verification
REQ-033 Reset, run QP_NUM=8192 -> wit_wr_en high with wit_wr_data=0 for exactly 8192 cycles, addresses 0..8191, then init_done=1, readies asserted.
REQ-034 set qpn=5, then lookup qpn=5 next cycle -> rsp_valid at lookup+1, rsp_data=1; clear qpn=5, lookup -> rsp_data=0.
REQ-035 set and clr both valid for 4 cycles, qpns 10 and 11 -> grants alternate set, clr, set, clr; no cycle with two writes.
REQ-036 WIT_COLLISION_FWD_EN defined, set qpn=7 and lookup qpn=7 in same cycle -> rsp_data=1 next cycle.
REQ-037 rst pulsed at init address 3000 -> counter restarts at 0, full 8192-cycle clear repeats, no rsp_valid during INIT.
REQ-038 Lookups to qpn 0..15 issued back-to-back -> 16 consecutive rsp_valid cycles, each 1 cycle after its request, data matching the written pattern.
